multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle sequencer for the RV32I core. It replaces single-cycle control decode with a state machine that steps one instruction through fetch, decode, execute, memory and writeback. The core then shares one memory port between instruction fetch and data access, and that port may stall. The block drives the same datapath controls as the single-cycle decoder, plus PC/IR write enables, a memory request handshake and a retired-instruction counter.

## Interface
Parameters
- `COUNT_W`, default 32: width of the retired-instruction counter.

Ports
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `opcode`  in  7  instruction[6:0] from the datapath IR; stable from DECODE until the next `ir_write`.
- `func3`  in  3  instruction[14:12] from the IR.
- `zero`  in  1  ALU zero flag, valid combinationally in EXECUTE.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.
- `mem_req`  out  1  memory request active.
- `mem_write`  out  1  request is a store.
- `mem_addr_source`  out  1  0 = PC, 1 = ALU result.
- `ir_write`  out  1  load fetched word into IR.
- `pc_write`  out  1  update PC at this edge.
- `pc_source_control`  out  1  0 = PC+4, 1 = PC+imm.
- `alu_control`  out  3  ALU operation.
- `alu_input2_source_control`  out  1  0 = immediate, 1 = rs2.
- `sign_ext_control`  out  2  0 = I-type, 1 = S-type, 2 = B-type.
- `reg_write_control`  out  1  register file write enable.
- `reg_write_data_source_control`  out  1  0 = ALU, 1 = memory data.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `instr_count`  out  COUNT_W  number of retired instructions.
- `illegal`  out  1  high in TRAP.

## Operation
- Legal instructions:
  - OP-IMM: opcode 0010011, any func3.
  - LOAD: opcode 0000011.
  - STORE: opcode 0100011.
  - BEQ: opcode 1100011 with func3 = 000.
  - Everything else is illegal.
- All outputs except `instr_count` are decoded combinationally from the registered state plus `opcode`, `func3`, `zero` and `mem_ready`. Any output not listed for a state is 0.
- FETCH:
  - `mem_req`=1, `mem_addr_source`=0.
  - If `mem_ready`: `ir_write`=1, go to DECODE. Otherwise stay.
- DECODE:
  - One cycle; `sign_ext_control` is set per opcode.
  - Legal: go to EXECUTE. Illegal: go to TRAP.
- EXECUTE:
  - OP-IMM: `alu_control`=func3, source 0, I-type; go to WRITEBACK.
  - LOAD/STORE: `alu_control`=0 (add), immediate source, I-type (load) or S-type (store); go to MEM.
  - BEQ: `alu_control`=1 (sub), `alu_input2_source_control`=1, B-type, `pc_write`=1, `pc_source_control`=`zero`, `retire`=1; go to FETCH.
- MEM:
  - ALU controls are held as in EXECUTE; `mem_req`=1, `mem_addr_source`=1, `mem_write`=1 for STORE.
  - Wait for `mem_ready`.
  - STORE: on ready, `pc_write`=1, `retire`=1; go to FETCH.
  - LOAD: on ready, go to WRITEBACK.
- WRITEBACK:
  - `reg_write_control`=1.
  - `reg_write_data_source_control`=1 for LOAD, 0 for OP-IMM.
  - `pc_write`=1, `pc_source_control`=0, `retire`=1; go to FETCH.
- TRAP:
  - Absorbing: `illegal`=1, no request and no write enables.
  - Left only by reset.
- `instr_count` increments by 1 on every edge where `retire`=1 and wraps modulo 2^COUNT_W.

## Timing
- Reset (`rst_n` low, async):
  - `state`=FETCH, `instr_count`=0.
  - `mem_req` is gated to 0 while `rst_n` is low; every other output is 0.
  - First request is issued in the cycle after `rst_n` rises (synchronous deassertion assumed upstream).
- Memory handshake:
  - The request is held constant (address source and write) until `mem_ready`.
  - The transfer completes in the same cycle `mem_ready` is high; zero-wait memory means ready in the first cycle.
  - `mem_ready` outside FETCH/MEM is ignored.
- Cycles per instruction with zero-wait memory:
  - OP-IMM 4, LOAD 5, STORE 4, BEQ 3.
  - Each memory wait cycle adds 1.
- `retire` is never high in two consecutive cycles; `pc_write` coincides exactly with `retire`.
- Reset mid-instruction abandons it: no `pc_write`, no `retire`; the count is cleared.

## Test plan
- Reset then OP-IMM (0x00500093) with zero-wait memory:
  - states 0,1,2,4,0.
  - `reg_write_control`=1 only in cycle 4.
  - `instr_count`=1 after 4 cycles.
- LOAD with `mem_ready` low for 3 cycles in MEM:
  - MEM lasts 4 cycles with `mem_addr_source`=1, `mem_write`=0.
  - WRITEBACK has `reg_write_data_source_control`=1; total 8 cycles.
- STORE:
  - `mem_write`=1 only in MEM, `sign_ext_control`=1 in EXECUTE.
  - `retire` in the MEM ready cycle; no `reg_write_control` at any point.
- BEQ with `zero`=1, then with `zero`=0:
  - 3 cycles each; `pc_source_control`=1 then 0, `pc_write`=1 in EXECUTE.
  - `instr_count` +2.
- Illegal opcode 0110011 and BEQ with func3=001:
  - TRAP after DECODE; `illegal`=1 held for 20 cycles.
  - `instr_count` unchanged; `mem_req`=0.
  - Reset returns the block to FETCH.
- Counter wrap with COUNT_W=4: 17 OP-IMM retires → `instr_count`=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle sequencer for an RV32I core.
// Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEM and
// WRITEBACK over a single shared, stallable memory port. Illegal encodings
// park the block in TRAP until reset. Counts retired instructions.
module multicycle_controller #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         state,
  output logic               mem_req,
  output logic               mem_write,
  output logic               mem_addr_source,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_source_control,
  output logic [2:0]         alu_control,
  output logic               alu_input2_source_control,
  output logic [1:0]         sign_ext_control,
  output logic               reg_write_control,
  output logic               reg_write_data_source_control,
  output logic               retire,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_t cur_state;
  state_t next_state;

  // Only BEQ is supported among the branch encodings.
  function automatic logic is_beq(input logic [6:0] op, input logic [2:0] f3);
    return (op == OPC_BRANCH) && (f3 == 3'b000);
  endfunction

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    return (op == OPC_OP_IMM) || (op == OPC_LOAD) || (op == OPC_STORE) || is_beq(op, f3);
  endfunction

  // Immediate format select: 0 = I-type, 1 = S-type, 2 = B-type.
  function automatic logic [1:0] ext_sel(input logic [6:0] op);
    if (op == OPC_STORE)  return 2'd1;
    if (op == OPC_BRANCH) return 2'd2;
    return 2'd0;
  endfunction

  assign state = cur_state;

  // Output decode and next-state selection from the registered state.
  always_comb begin
    next_state                    = cur_state;
    mem_req                       = 1'b0;
    mem_write                     = 1'b0;
    mem_addr_source               = 1'b0;
    ir_write                      = 1'b0;
    pc_write                      = 1'b0;
    pc_source_control             = 1'b0;
    alu_control                   = 3'd0;
    alu_input2_source_control     = 1'b0;
    sign_ext_control              = 2'd0;
    reg_write_control             = 1'b0;
    reg_write_data_source_control = 1'b0;
    retire                        = 1'b0;
    illegal                       = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        sign_ext_control = ext_sel(opcode);
        next_state       = is_legal(opcode, func3) ? EXECUTE : TRAP;
      end
      EXECUTE: begin
        sign_ext_control = ext_sel(opcode);
        if (opcode == OPC_OP_IMM) begin
          alu_control = func3;
          next_state  = WRITEBACK;
        end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
          next_state = MEM;
        end else if (is_beq(opcode, func3)) begin
          alu_control               = 3'd1;
          alu_input2_source_control = 1'b1;
          pc_write                  = 1'b1;
          pc_source_control         = zero;
          retire                    = 1'b1;
          next_state                = FETCH;
        end else begin
          // Opcode changed under us; treat as illegal rather than guess.
          next_state = TRAP;
        end
      end
      MEM: begin
        // Address and direction stay put until the memory accepts.
        sign_ext_control = ext_sel(opcode);
        mem_req          = 1'b1;
        mem_addr_source  = 1'b1;
        mem_write        = (opcode == OPC_STORE);
        if (mem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        reg_write_control             = 1'b1;
        reg_write_data_source_control = (opcode == OPC_LOAD);
        pc_write                      = 1'b1;
        retire                        = 1'b1;
        next_state                    = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        next_state = TRAP;
      end
    endcase
    // Nothing may reach memory or the datapath while reset is held.
    if (!rst_n) begin
      mem_req                       = 1'b0;
      mem_write                     = 1'b0;
      mem_addr_source               = 1'b0;
      ir_write                      = 1'b0;
      pc_write                      = 1'b0;
      pc_source_control             = 1'b0;
      alu_control                   = 3'd0;
      alu_input2_source_control     = 1'b0;
      sign_ext_control              = 2'd0;
      reg_write_control             = 1'b0;
      reg_write_data_source_control = 1'b0;
      retire                        = 1'b0;
      illegal                       = 1'b0;
    end
  end

  // State register and wrapping retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= FETCH;
      instr_count <= '0;
    end else begin
      cur_state <= next_state;
      if (retire) instr_count <= instr_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed table, corner sequences and
// randomized instruction streams against a cycle-script reference model.
module tb_multicycle_controller;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    func3 = 3'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic [2:0]    state;
  logic          mem_req, mem_write, mem_addr_source, ir_write, pc_write;
  logic          pc_source_control;
  logic [2:0]    alu_control;
  logic          alu_input2_source_control;
  logic [1:0]    sign_ext_control;
  logic          reg_write_control, reg_write_data_source_control, retire;
  logic [CW-1:0] instr_count;
  logic          illegal;

  always #5 clk = ~clk;

  multicycle_controller #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .zero(zero),
    .mem_ready(mem_ready), .state(state), .mem_req(mem_req),
    .mem_write(mem_write), .mem_addr_source(mem_addr_source),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_source_control(pc_source_control), .alu_control(alu_control),
    .alu_input2_source_control(alu_input2_source_control),
    .sign_ext_control(sign_ext_control), .reg_write_control(reg_write_control),
    .reg_write_data_source_control(reg_write_data_source_control),
    .retire(retire), .instr_count(instr_count), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req, wr, mas, irw, pcw, pcs;
    logic [2:0] alu;
    logic       a2;
    logic [1:0] sx;
    logic       rw, rwds, ret, ill;
  } outs_t;

  typedef struct {
    logic  rdy;
    logic  z;
    outs_t o;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    int         fw;
    int         mw;
    int         exp_cyc;
    int         exp_ret;
  } vec_t;

  outs_t act;
  assign act = {state, mem_req, mem_write, mem_addr_source, ir_write, pc_write,
                pc_source_control, alu_control, alu_input2_source_control,
                sign_ext_control, reg_write_control,
                reg_write_data_source_control, retire, illegal};

  step_t steps[$];
  int    errors = 0;
  int    checks = 0;
  int    model_cnt = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
    return op == 7'b0010011 || op == 7'b0000011 || op == 7'b0100011 ||
           (op == 7'b1100011 && f3 == 3'b000);
  endfunction

  task automatic check_val(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic push(input logic rdy, input logic z, input outs_t o);
    step_t s;
    s.rdy = rdy; s.z = z; s.o = o;
    steps.push_back(s);
  endtask

  // Expected per-cycle behaviour of one instruction, written from the
  // instruction-level rules: fetch (with waits), decode, then the phases
  // that instruction class needs.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input int fw, input int mw, input int trap_n);
    outs_t      o;
    int         cls;
    logic [1:0] sx;
    steps.delete();
    cls = (op == 7'b0010011) ? 0 : (op == 7'b0000011) ? 1 :
          (op == 7'b0100011) ? 2 : legal(op, f3) ? 3 : 4;
    sx = (cls == 2) ? 2'd1 : (op == 7'b1100011) ? 2'd2 : 2'd0;
    for (int i = 0; i <= fw; i++) begin
      o = '0; o.req = 1'b1; o.irw = (i == fw);
      push(i == fw, rb(), o);
    end
    o = '0; o.st = 3'd1; o.sx = sx;
    push(rb(), rb(), o);
    if (cls == 4) begin
      for (int i = 0; i < trap_n; i++) begin
        o = '0; o.st = 3'd5; o.ill = 1'b1;
        push(rb(), rb(), o);
      end
      return;
    end
    o = '0; o.st = 3'd2; o.sx = sx;
    if (cls == 0) o.alu = f3;
    if (cls == 3) begin
      o.alu = 3'd1; o.a2 = 1'b1; o.pcw = 1'b1; o.pcs = z; o.ret = 1'b1;
    end
    push(rb(), (cls == 3) ? z : rb(), o);
    if (cls == 1 || cls == 2) begin
      for (int i = 0; i <= mw; i++) begin
        o = '0; o.st = 3'd3; o.req = 1'b1; o.mas = 1'b1; o.sx = sx;
        o.wr = (cls == 2);
        if (i == mw && cls == 2) begin o.pcw = 1'b1; o.ret = 1'b1; end
        push(i == mw, rb(), o);
      end
    end
    if (cls == 0 || cls == 1) begin
      o = '0; o.st = 3'd4; o.rw = 1'b1; o.rwds = (cls == 1); o.pcw = 1'b1; o.ret = 1'b1;
      push(rb(), rb(), o);
    end
  endtask

  // Apply the scripted cycles; abort_at >= 0 stops early (for reset tests).
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input int abort_at,
                     output int ret_cycle, output int ret_n);
    int n;
    ret_cycle = 0; ret_n = 0;
    n = steps.size();
    if (abort_at >= 0 && abort_at < n) n = abort_at;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin opcode = op; func3 = f3; end
      mem_ready = steps[k].rdy;
      zero      = steps[k].z;
      #1;
      check_val($sformatf("cyc%0d outputs op=%b", k, op), 32'(act), 32'(steps[k].o));
      check_val($sformatf("cyc%0d instr_count", k), 32'(instr_count), 32'(model_cnt));
      if (retire) begin
        ret_n++;
        if (ret_cycle == 0) ret_cycle = k + 1;
      end
      if (steps[k].o.ret) model_cnt = (model_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
    #1;
    check_val("reset outputs", 32'(act), 32'd0);
    check_val("reset instr_count", 32'(instr_count), 32'd0);
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    check_val("first request after reset", {31'd0, mem_req}, 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   rc, rn, r, fw, mw, ab;
    logic [6:0] op;
    logic [2:0] f3;

    vecs[0] = '{7'b0010011, 3'b000, 1'b0, 0, 0, 4, 1};  // addi x1,x0,5
    vecs[1] = '{7'b0000011, 3'b010, 1'b0, 0, 3, 8, 1};  // lw, 3 wait cycles
    vecs[2] = '{7'b0100011, 3'b010, 1'b0, 0, 0, 4, 1};  // sw
    vecs[3] = '{7'b1100011, 3'b000, 1'b1, 0, 0, 3, 1};  // beq taken
    vecs[4] = '{7'b1100011, 3'b000, 1'b0, 0, 0, 3, 1};  // beq not taken
    vecs[5] = '{7'b0010011, 3'b111, 1'b1, 2, 0, 6, 1};  // andi, fetch stalls 2

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      build(vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].fw, vecs[i].mw, 0);
      run(vecs[i].op, vecs[i].f3, -1, rc, rn);
      check_val($sformatf("vec%0d cycles to retire", i), rc, vecs[i].exp_cyc);
      check_val($sformatf("vec%0d retire pulses", i), rn, vecs[i].exp_ret);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_val("count after table", 32'(instr_count), 32'd6);

    // Illegal opcode, then BEQ with a non-zero func3: both trap and stay.
    build(7'b0110011, 3'b000, 1'b0, 0, 0, 20);
    run(7'b0110011, 3'b000, -1, rc, rn);
    check_val("illegal op retires", rn, 0);
    check_val("count after trap", 32'(instr_count), 32'd6);
    do_reset();
    build(7'b1100011, 3'b001, 1'b1, 1, 0, 20);
    run(7'b1100011, 3'b001, -1, rc, rn);
    check_val("bne retires", rn, 0);
    do_reset();

    // Reset in the middle of a stalled load: abandoned, nothing retires.
    build(7'b0000011, 3'b010, 1'b0, 0, 3, 0);
    run(7'b0000011, 3'b010, 5, rc, rn);
    check_val("abandoned load state", 32'(state), 32'd3);
    do_reset();

    // Counter wrap: 17 retires modulo 16.
    for (int i = 0; i < 17; i++) begin
      f3 = 3'($urandom);
      build(7'b0010011, f3, 1'b0, 0, 0, 0);
      run(7'b0010011, f3, -1, rc, rn);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_val("count wrap", 32'(instr_count), 32'd1);

    // Randomized instruction stream.
    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(0, 9);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      f3 = 3'($urandom);
      case (r)
        0, 1, 2: op = 7'b0010011;
        3, 4:    op = 7'b0000011;
        5, 6:    op = 7'b0100011;
        7, 8:    begin op = 7'b1100011; f3 = 3'b000; end
        default: begin
          op = 7'($urandom);
          while (legal(op, f3)) op = 7'($urandom);
        end
      endcase
      build(op, f3, rb(), fw, mw, $urandom_range(1, 5));
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 6) : -1;
      run(op, f3, ab, rc, rn);
      if (ab >= 0 || !legal(op, f3)) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
